sram_arbiter: RTL
=================

// Module: sram_arbiter
// PURPOSE
//  Shares the single cartridge SRAM between SNES bus cycles and AVR byte requests.
//  Drives the bus-phase MODE signal into address decode: MODE=0 for SNES, MODE=1 for AVR.
//  Sequences SRAM_OE_N, SRAM_WE_N and the data-bus drivers for each phase.
//  AVR accesses are placed only in SNES idle gaps; the SNES side has absolute priority.
// PARAMETERS
//  T_ACC    3  SRAM access time in CLK cycles (strobe low time), 1..15
//  T_GUARD  2  SNES-idle cycles required before an AVR access may start, 0..15
// PORTS
//  CLK           in   1   system clock
//  RST_N         in   1   asynchronous reset, active low
//  SNES_RD_N     in   1   SNES read strobe, asynchronous to CLK
//  SNES_WR_N     in   1   SNES write strobe, asynchronous to CLK
//  IS_SAVERAM    in   1   decode: current SNES address is SaveRAM (SNES writes allowed)
//  AVR_REQ       in   1   AVR request; level, held until AVR_ACK
//  AVR_WE        in   1   1 = write, 0 = read; sampled with AVR_REQ
//  AVR_WDATA     in   8   AVR write byte; sampled with AVR_REQ
//  AVR_ACK       out  1   one-cycle pulse, access complete
//  AVR_RDATA     out  8   read byte, valid from the AVR_ACK cycle until next ACK
//  MODE          out  1   bus phase to address decode (1 = AVR)
//  SRAM_OE_N     out  1   SRAM output enable, active low
//  SRAM_WE_N     out  1   SRAM write enable, active low
//  SRAM_DQ_IN    in   8   SRAM data bus, read side
//  SRAM_DQ_OUT   out  8   SRAM data bus, write value
//  SRAM_DQ_OE    out  1   FPGA drives SRAM data bus when 1
//  COLLIDE_CNT   out  8   saturating count of SNES strobes seen during AVR_ACC
// BEHAVIOUR
//  Reset values:
//   - MODE=0, SRAM_OE_N=1, SRAM_WE_N=1, SRAM_DQ_OE=0, AVR_ACK=0.
//   - AVR_RDATA=0, SRAM_DQ_OUT=0, COLLIDE_CNT=0. FSM in IDLE.
//  Strobe synchronisation:
//   - SNES_RD_N and SNES_WR_N each pass through a 2-FF synchroniser.
//   - snes_act = !rd_s | !wr_s; two cycles of input latency.
//  Idle counter:
//   - idle_cnt clears while snes_act=1, otherwise increments, saturating at 15.
//  FSM states: IDLE, SNES, AVR_SETUP, AVR_ACC, AVR_DONE.
//  IDLE:
//   - snes_act=1 -> SNES. This takes priority over a pending AVR_REQ in the same cycle.
//   - Else if AVR_REQ=1 and idle_cnt>=T_GUARD -> AVR_SETUP; latch AVR_WE and AVR_WDATA.
//  SNES:
//   - MODE=0, SRAM_OE_N=rd_s, SRAM_WE_N=!(!wr_s & IS_SAVERAM).
//   - SRAM_DQ_OE=0: SNES write data reaches the SRAM by a path outside this block.
//   - Returns to IDLE when snes_act=0.
//  AVR_SETUP (1 cycle):
//   - MODE=1, both strobes high; address settles.
//   - SRAM_DQ_OE=latched WE; SRAM_DQ_OUT=latched wdata.
//  AVR_ACC (T_ACC cycles, counter reloads on entry):
//   - MODE=1; SRAM_OE_N=WE; SRAM_WE_N=!WE.
//   - On the final cycle of a read, AVR_RDATA<=SRAM_DQ_IN.
//  AVR_DONE (1 cycle):
//   - Strobes high; MODE stays 1 and DQ_OE stays at its AVR_SETUP value (hold time).
//   - AVR_ACK=1; next state IDLE. MODE returns to 0 in IDLE.
//  Collisions:
//   - An AVR access is never aborted.
//   - A rising edge of snes_act during AVR_ACC increments COLLIDE_CNT (saturates at 255).
//   - The SNES phase starts after AVR_DONE.
//  AVR_REQ rules:
//   - Still high in the cycle after AVR_ACK: a new request, arbitrated again with the full guard check.
//   - Dropped before service: ignored; no ACK.
//  Reset mid-operation:
//   - Immediate return to reset values. No ACK for an in-flight access; the SRAM write may be partial.
//  Widths:
//   - The T_ACC counter is 4 bits and loads T_ACC-1.
//   - The idle counter is 4 bits, saturating at 15.
//   - All comparisons are unsigned.
// TESTING
//  1 AVR write 0xA5, SNES idle, T_ACC=3 -> SETUP 1 cycle, WE_N low 3 cycles, ACK 5 cycles after grant, DQ_OE high throughout.
//  2 AVR read, SRAM_DQ_IN=0x3C -> OE_N low 3 cycles, AVR_RDATA=0x3C at ACK, no WE_N pulse.
//  3 SNES_RD_N low and AVR_REQ rise in the same cycle -> SNES phase, MODE=0.
//    After RD_N rises, grant only after T_GUARD=2 idle cycles.
//  4 SNES_WR_N low with IS_SAVERAM=0 -> SRAM_WE_N stays 1; with IS_SAVERAM=1 -> WE_N follows wr_s.
//  5 SNES_RD_N falls mid-AVR_ACC -> access completes, ACK issued, COLLIDE_CNT 0->1.
//    Force 300 collisions -> COLLIDE_CNT=255.
//  6 RST_N low during AVR_ACC -> outputs at reset values asynchronously, no ACK.
//    After release, a pending AVR_REQ is served normally.

Source files
------------

// File: rtl/sram_arbiter.sv
// Cartridge SRAM arbiter: SNES bus cycles have absolute priority, AVR byte
// accesses are slotted into SNES idle gaps. All SRAM-side outputs are registered.
module sram_arbiter #(
  parameter int unsigned T_ACC   = 3,
  parameter int unsigned T_GUARD = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SNES_RD_N,
  input  logic       SNES_WR_N,
  input  logic       IS_SAVERAM,
  input  logic       AVR_REQ,
  input  logic       AVR_WE,
  input  logic [7:0] AVR_WDATA,
  output logic       AVR_ACK,
  output logic [7:0] AVR_RDATA,
  output logic       MODE,
  output logic       SRAM_OE_N,
  output logic       SRAM_WE_N,
  input  logic [7:0] SRAM_DQ_IN,
  output logic [7:0] SRAM_DQ_OUT,
  output logic       SRAM_DQ_OE,
  output logic [7:0] COLLIDE_CNT
);

  typedef enum logic [2:0] {
    IDLE,
    SNES,
    AVR_SETUP,
    AVR_ACC,
    AVR_DONE
  } state_t;

  state_t     state;
  logic       rd_m, rd_s, wr_m, wr_s;
  logic       snes_act, snes_act_d;
  logic [3:0] idle_cnt;
  logic [3:0] acc_cnt;
  logic       we_l;

  assign snes_act = ~rd_s | ~wr_s;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_m       <= 1'b1;
      rd_s       <= 1'b1;
      wr_m       <= 1'b1;
      wr_s       <= 1'b1;
      snes_act_d <= 1'b0;
    end else begin
      rd_m       <= SNES_RD_N;
      rd_s       <= rd_m;
      wr_m       <= SNES_WR_N;
      wr_s       <= wr_m;
      snes_act_d <= snes_act;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idle_cnt <= '0;
    end else if (snes_act) begin
      idle_cnt <= '0;
    end else if (idle_cnt != 4'hF) begin
      idle_cnt <= idle_cnt + 4'd1;
    end
  end

  // A SNES strobe arriving mid-access cannot abort it; it is only counted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      COLLIDE_CNT <= '0;
    end else if (state == AVR_ACC && snes_act && !snes_act_d && COLLIDE_CNT != 8'hFF) begin
      COLLIDE_CNT <= COLLIDE_CNT + 8'd1;
    end
  end

  // Outputs are assigned on the transition into a state, so they always
  // reflect the current state; the SNES strobes therefore lag rd_s/wr_s by one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      MODE        <= 1'b0;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      SRAM_DQ_OE  <= 1'b0;
      SRAM_DQ_OUT <= '0;
      AVR_ACK     <= 1'b0;
      AVR_RDATA   <= '0;
      we_l        <= 1'b0;
      acc_cnt     <= '0;
    end else begin
      AVR_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (snes_act) begin
            state      <= SNES;
            MODE       <= 1'b0;
            SRAM_OE_N  <= rd_s;
            SRAM_WE_N  <= ~(~wr_s & IS_SAVERAM);
            SRAM_DQ_OE <= 1'b0;
          end else if (AVR_REQ && idle_cnt >= 4'(T_GUARD)) begin
            state       <= AVR_SETUP;
            we_l        <= AVR_WE;
            MODE        <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
            SRAM_DQ_OE  <= AVR_WE;
            SRAM_DQ_OUT <= AVR_WDATA;
          end
        end
        SNES: begin
          if (snes_act) begin
            SRAM_OE_N <= rd_s;
            SRAM_WE_N <= ~(~wr_s & IS_SAVERAM);
          end else begin
            state     <= IDLE;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
          end
        end
        AVR_SETUP: begin
          state     <= AVR_ACC;
          acc_cnt   <= 4'(T_ACC - 1);
          SRAM_OE_N <= we_l;
          SRAM_WE_N <= ~we_l;
        end
        AVR_ACC: begin
          if (acc_cnt == 4'd0) begin
            state     <= AVR_DONE;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            AVR_ACK   <= 1'b1;
            if (!we_l) begin
              AVR_RDATA <= SRAM_DQ_IN;
            end
          end else begin
            acc_cnt <= acc_cnt - 4'd1;
          end
        end
        AVR_DONE: begin
          state      <= IDLE;
          MODE       <= 1'b0;
          SRAM_DQ_OE <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
